lit_compile: RTL and testbench
==============================

Name: lit_compile

Overview:
- Compile-side front end that feeds the byte comma stage.
- Takes one compile request and emits it as a stream of byte writes through the comma handshake: an opcode byte, then optionally a little-endian literal cell.
- Owns the dictionary HERE pointer and advances it once per byte written.
- Sits between the outer-interpreter/compiler control and the comma stage, which drives the memory block.

Parameters:
- DSZ, 8, byte data width toward comma.
- ASZ, 17, address width (128K).
- CSZ, 32, literal cell width; must be a multiple of DSZ.
- HERE0, 0, reset value of HERE.
- MEM_TOP, 2**ASZ-1, highest writable address.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- req  input  1  start a compile, sampled only in IDLE
- op  input  DSZ  opcode byte
- has_lit  input  1  1: append CSZ/DSZ literal bytes after the opcode
- lit  input  CSZ  literal value
- here_ld  input  1  load HERE from here_i, honoured only in IDLE
- here_i  input  ASZ  new HERE
- here_o  output  ASZ  current HERE
- cm_en  output  1  comma enable, held through each byte
- cm_ai  output  ASZ  byte address to comma
- cm_vi  output  DSZ  byte value to comma
- cm_ack  input  1  comma reports the byte written
- bsy  output  1  request in progress
- done  output  1  one-cycle pulse at completion
- err  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Single clock domain. Reset is synchronous and active-low on clk, via rst.
- Reset (rst=0), including mid-operation:
  - state=IDLE, here_o=HERE0
  - cm_en=0, cm_ai=0, cm_vi=0
  - bsy=0, done=0, err=0
  - a partially emitted request is abandoned; HERE keeps only the reset value.
- States: IDLE, CHK, BYTE, GAP, FIN.
- IDLE:
  - here_ld=1: HERE<=here_i next cycle. here_ld has priority and the same-cycle req is dropped with no err.
  - Otherwise req=1: latch op, lit and has_lit; compute N = 1 + (has_lit ? CSZ/DSZ : 0); go to CHK.
- CHK, one cycle, bsy=1:
  - If HERE+N-1 > MEM_TOP, using ASZ+1-bit arithmetic so there is no wrap: err=1 for one cycle, go to IDLE, no writes, HERE unchanged.
  - Otherwise go to BYTE with byte index k=0.
- BYTE:
  - cm_en=1, cm_ai=HERE, cm_vi=byte k.
  - Byte 0 is op. Byte k≥1 is lit[(k-1)*DSZ +: DSZ], i.e. little-endian.
  - Outputs are registered and stable while cm_en=1.
  - On cm_ack=1: HERE<=HERE+1, k<=k+1, go to GAP.
  - cm_ack while cm_en=0 is ignored.
- GAP, one cycle, cm_en=0 (lets comma return to its idle state): go to BYTE if k<N, else FIN.
- FIN, one cycle: done=1, bsy=0 next cycle, go to IDLE.
- bsy=1 in CHK, BYTE, GAP and FIN; bsy=0 in IDLE.
- req or here_ld while bsy=1: ignored, not queued.
- Cost per byte: ack latency + 1 cycle. With ack on the 2nd cycle of cm_en, each byte takes 3 cycles.
- No timeout: the block waits in BYTE indefinitely for cm_ack.

Optional Feature:
- Macro: LIT_ALIGN_EN.
- Defined, and has_lit=1:
  - After the opcode, emit zero pad bytes (value 0) until HERE is a multiple of CSZ/DSZ, then emit the literal. Pad count is 0..CSZ/DSZ-1.
  - N includes the pad bytes, and the CHK bound check uses that N.
  - Each pad byte goes through BYTE/GAP like any other byte.
- Undefined: no padding; the literal immediately follows the opcode.
- has_lit=0: identical with or without the macro.

Decomposition:
- Shared package forthsuper_pkg holds:
  - the lit_compile_sts enum {IDLE, CHK, BYTE, GAP, FIN}
  - the constant CELL_BYTES = CSZ/DSZ.
- Single module; no sub-module needed. Byte selection is an indexed part-select inside the module.

Test Plan:
- Plain opcode. Reset → here_o=0. Then req, op=8'h3A, has_lit=0, bench acks on the 2nd cm_en cycle → one write (ai=0, vi=3A), done pulses, here_o=1, bsy high for exactly 5 cycles (CHK, 2 BYTE, GAP, FIN).
- Literal. here_ld with here_i=17'h00100, then req, op=8'h01, has_lit=1, lit=32'hDEADBEEF → writes at 100..104 with values 01, EF, BE, AD, DE; here_o=17'h00105.
- Bound check. HERE=MEM_TOP-2, req with has_lit=1 → err pulse the cycle after CHK, no cm_en, here_o unchanged. A following has_lit=0 request succeeds.
- Priority and busy. req and here_ld together in IDLE → HERE loaded, no writes. A second req mid-transfer → ignored, exactly 5 writes total.
- Reset mid-operation. rst=0 after the 2nd ack of a literal request → next cycle state=IDLE, cm_en=0, here_o=HERE0, no done pulse.
- With LIT_ALIGN_EN. HERE=17'h00101, req op=8'h01, lit=32'h11223344 → writes 01@101, 00@102, 00@103, then 44, 33, 22, 11 @104..107; here_o=17'h00108.

Source files
------------

// File: rtl/forthsuper_pkg.sv
// Shared types and constants for the forthsuper compile path.
package forthsuper_pkg;

  typedef enum logic [2:0] {IDLE, CHK, BYTE, GAP, FIN} lit_compile_sts;

  localparam int DSZ_DEF    = 8;
  localparam int CSZ_DEF    = 32;
  localparam int CELL_BYTES = CSZ_DEF / DSZ_DEF;

endpackage

// File: rtl/lit_compile.sv
// Compile front end: turns one request into opcode + literal byte writes via comma, owning HERE.
// Build option LIT_ALIGN_EN: zero-pad after the opcode so the literal starts cell aligned.
module lit_compile
  import forthsuper_pkg::*;
#(
  parameter int              DSZ     = DSZ_DEF,
  parameter int              ASZ     = 17,
  parameter int              CSZ     = CSZ_DEF,
  parameter logic [ASZ-1:0]  HERE0   = '0,
  parameter int unsigned     MEM_TOP = 2**ASZ - 1
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [DSZ-1:0] op,
  input  logic           has_lit,
  input  logic [CSZ-1:0] lit,
  input  logic           here_ld,
  input  logic [ASZ-1:0] here_i,
  output logic [ASZ-1:0] here_o,
  output logic           cm_en,
  output logic [ASZ-1:0] cm_ai,
  output logic [DSZ-1:0] cm_vi,
  input  logic           cm_ack,
  output logic           bsy,
  output logic           done,
  output logic           err
);

  localparam int NB = CSZ / DSZ;
  localparam int KW = $clog2(2*NB + 1);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  lit_compile_sts state_reg, state_next;

  logic [ASZ-1:0] here_reg;
  logic [DSZ-1:0] op_reg;
  logic [CSZ-1:0] lit_reg;
  logic [KW-1:0]  k_reg, n_reg, pad_reg;
  logic [KW-1:0]  pad_calc, n_calc, lit_idx;
  logic [ASZ:0]   last_addr;
  logic           ovf;
  logic [DSZ-1:0] byte_val;
  logic [DSZ-1:0] lit_bytes [NB];

  logic           cm_en_reg, cm_en_next;
  logic [ASZ-1:0] cm_ai_reg, cm_ai_next;
  logic [DSZ-1:0] cm_vi_reg, cm_vi_next;
  logic           done_reg, done_next;
  logic           err_reg, err_next;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lit_bytes
      assign lit_bytes[gi] = lit_reg[gi*DSZ +: DSZ];
    end
  endgenerate

  // Byte count for an incoming request; pad depends on where the literal would start.
  always_comb begin
    pad_calc = '0;
`ifdef LIT_ALIGN_EN
    if (has_lit) begin : g_pad
      int unsigned rem;
      rem = (int'(here_reg) + 1) % NB;
      pad_calc = (rem == 0) ? KW'(0) : KW'(NB - int'(rem));
    end
`endif
    n_calc = KW'(1) + pad_calc + (has_lit ? KW'(NB) : KW'(0));
  end

  // Extra top bit keeps the end address from wrapping past MEM_TOP.
  always_comb begin
    last_addr = {1'b0, here_reg} + (ASZ+1)'(n_reg) - (ASZ+1)'(1);
    ovf       = last_addr > (ASZ+1)'(MEM_TOP);
  end

  // Byte 0 is the opcode, then pad zeros, then literal bytes low first.
  always_comb begin
    byte_val = '0;
    lit_idx  = k_reg - pad_reg - KW'(1);
    if (k_reg == '0)
      byte_val = op_reg;
    else if (k_reg > pad_reg)
      byte_val = lit_bytes[IW'(lit_idx)];
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (!here_ld && req) state_next = CHK;
      CHK:  state_next = ovf ? IDLE : BYTE;
      BYTE: if (cm_ack) state_next = GAP;
      GAP:  state_next = (k_reg < n_reg) ? BYTE : FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    cm_en_next = (state_next == BYTE);
    cm_ai_next = cm_en_next ? here_reg : '0;
    cm_vi_next = cm_en_next ? byte_val : '0;
    done_next  = (state_next == FIN);
    err_next   = (state_reg == CHK) && ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      here_reg  <= HERE0;
      op_reg    <= '0;
      lit_reg   <= '0;
      k_reg     <= '0;
      n_reg     <= '0;
      pad_reg   <= '0;
      cm_en_reg <= 1'b0;
      cm_ai_reg <= '0;
      cm_vi_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      cm_en_reg <= cm_en_next;
      cm_ai_reg <= cm_ai_next;
      cm_vi_reg <= cm_vi_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      case (state_reg)
        IDLE: begin
          if (here_ld) begin
            here_reg <= here_i;
          end else if (req) begin
            op_reg  <= op;
            lit_reg <= lit;
            n_reg   <= n_calc;
            pad_reg <= pad_calc;
            k_reg   <= '0;
          end
        end
        BYTE: begin
          if (cm_ack) begin
            here_reg <= here_reg + ASZ'(1);
            k_reg    <= k_reg + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign here_o = here_reg;
  assign cm_en  = cm_en_reg;
  assign cm_ai  = cm_ai_reg;
  assign cm_vi  = cm_vi_reg;
  assign done   = done_reg;
  assign err    = err_reg;
  assign bsy    = (state_reg != IDLE);

endmodule

// File: tb/tb_lit_compile.sv
// Directed bench for lit_compile with a comma responder that acks on the 2nd enabled cycle.
module tb_lit_compile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  op = '0;
  logic        has_lit = 1'b0;
  logic [31:0] lit = '0;
  logic        here_ld = 1'b0;
  logic [16:0] here_i = '0;
  logic [16:0] here_o;
  logic        cm_en;
  logic [16:0] cm_ai;
  logic [7:0]  cm_vi;
  logic        cm_ack;
  logic        bsy, done, err;

  int checks = 0;
  int errors = 0;

  int bsy_cnt = 0, done_cnt = 0, err_cnt = 0, en_cnt = 0;
  logic [16:0] wr_ai [$];
  logic [7:0]  wr_vi [$];

  lit_compile dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .has_lit(has_lit), .lit(lit),
    .here_ld(here_ld), .here_i(here_i), .here_o(here_o),
    .cm_en(cm_en), .cm_ai(cm_ai), .cm_vi(cm_vi), .cm_ack(cm_ack),
    .bsy(bsy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Comma model: ack on the 2nd cycle of cm_en, log each write, count status pulses.
  initial begin
    int run;
    run = 0;
    cm_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (cm_en) begin
        run++;
        en_cnt++;
        if (run == 2) begin
          cm_ack = 1'b1;
          wr_ai.push_back(cm_ai);
          wr_vi.push_back(cm_vi);
          $display("write addr=%05h data=%02h", cm_ai, cm_vi);
        end else begin
          cm_ack = 1'b0;
        end
      end else begin
        run = 0;
        cm_ack = 1'b0;
      end
      if (bsy)  bsy_cnt++;
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [16:0] h);
    @(negedge clk);
    here_ld = 1'b1;
    here_i  = h;
    @(negedge clk);
    here_ld = 1'b0;
  endtask

  task automatic request(input logic [7:0] o, input logic hl, input logic [31:0] l);
    @(negedge clk);
    req = 1'b1; op = o; has_lit = hl; lit = l;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 300;
    while (bsy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("idle_reached", {63'd0, bsy}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int w0, d0, e0, en0, b0, budget, nexp;
    logic [7:0] exp_lit [5];
    logic [7:0] exp_mid [5];
    logic [7:0] exp_al  [7];

    // Reset state
    tick(3);
    check("rst_here", 64'(here_o), 64'h0);
    check("rst_bsy",  64'(bsy), 64'h0);
    check("rst_cm_en", 64'(cm_en), 64'h0);
    check("rst_done_err", 64'({done, err}), 64'h0);
    rst = 1'b1;
    tick(1);

    // Plain opcode
    w0 = wr_ai.size(); d0 = done_cnt; b0 = bsy_cnt;
    request(8'h3A, 1'b0, 32'h0);
    wait_idle();
    check("plain_writes", 64'(wr_ai.size() - w0), 64'd1);
    check("plain_ai", 64'(wr_ai[w0]), 64'h0);
    check("plain_vi", 64'(wr_vi[w0]), 64'h3A);
    check("plain_done", 64'(done_cnt - d0), 64'd1);
    check("plain_bsy_cycles", 64'(bsy_cnt - b0), 64'd5);
    check("plain_here", 64'(here_o), 64'h1);

    // Literal
    load(17'h00100);
    check("ld_here", 64'(here_o), 64'h100);
    w0 = wr_ai.size();
    exp_lit = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    request(8'h01, 1'b1, 32'hDEADBEEF);
    wait_idle();
    check("lit_writes", 64'(wr_ai.size() - w0), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lit_ai%0d", i), 64'(wr_ai[w0+i]), 64'(17'h100 + i));
      check($sformatf("lit_vi%0d", i), 64'(wr_vi[w0+i]), 64'(exp_lit[i]));
    end
    check("lit_here", 64'(here_o), 64'h105);

    // Bound check, then a fitting plain request
    load(17'h1FFFD);
    e0 = err_cnt; en0 = en_cnt; d0 = done_cnt; w0 = wr_ai.size();
    request(8'h01, 1'b1, 32'h12345678);
    wait_idle();
    check("bound_err", 64'(err_cnt - e0), 64'd1);
    check("bound_no_en", 64'(en_cnt - en0), 64'd0);
    check("bound_no_done", 64'(done_cnt - d0), 64'd0);
    check("bound_here", 64'(here_o), 64'h1FFFD);
    request(8'h02, 1'b0, 32'h0);
    wait_idle();
    check("bound_plain_writes", 64'(wr_ai.size() - w0), 64'd1);
    check("bound_plain_ai", 64'(wr_ai[w0]), 64'h1FFFD);
    check("bound_plain_vi", 64'(wr_vi[w0]), 64'h02);
    check("bound_plain_here", 64'(here_o), 64'h1FFFE);
    check("bound_err_once", 64'(err_cnt - e0), 64'd1);

    // Priority: here_ld beats req in the same cycle
    en0 = en_cnt; e0 = err_cnt;
    @(negedge clk);
    req = 1'b1; here_ld = 1'b1; here_i = 17'h00203; op = 8'h55; has_lit = 1'b0;
    @(negedge clk);
    req = 1'b0; here_ld = 1'b0;
    tick(4);
    check("prio_here", 64'(here_o), 64'h203);
    check("prio_no_en", 64'(en_cnt - en0), 64'd0);
    check("prio_bsy", 64'(bsy), 64'h0);
    check("prio_no_err", 64'(err_cnt - e0), 64'd0);

    // Busy: a second req mid-transfer is dropped
    w0 = wr_ai.size(); d0 = done_cnt;
    exp_mid = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};
    request(8'hAA, 1'b1, 32'h04030201);
    tick(4);
    req = 1'b1; op = 8'h99; has_lit = 1'b0;
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    tick(4);
    check("busy_writes", 64'(wr_ai.size() - w0), 64'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("busy_vi%0d", i), 64'(wr_vi[w0+i]), 64'(exp_mid[i]));
    check("busy_here", 64'(here_o), 64'h208);
    check("busy_done", 64'(done_cnt - d0), 64'd1);

    // Reset after the 2nd ack of a literal request
    load(17'h00300);
    w0 = wr_ai.size(); d0 = done_cnt;
    request(8'h77, 1'b1, 32'h0A0B0C0D);
    budget = 100;
    while ((wr_ai.size() - w0) < 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("rst_mid_reached", 64'(wr_ai.size() - w0), 64'd2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_bsy", 64'(bsy), 64'h0);
    check("rst_mid_cm_en", 64'(cm_en), 64'h0);
    check("rst_mid_cm_ai_vi", 64'({cm_ai, cm_vi}), 64'h0);
    check("rst_mid_here", 64'(here_o), 64'h0);
    rst = 1'b1;
    tick(5);
    check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_mid_writes", 64'(wr_ai.size() - w0), 64'd2);
    check("rst_mid_here_after", 64'(here_o), 64'h0);

    // Literal starting off a cell boundary
    load(17'h00101);
    w0 = wr_ai.size();
`ifdef LIT_ALIGN_EN
    exp_al = '{8'h01, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    nexp = 7;
`else
    exp_al = '{8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h00};
    nexp = 5;
`endif
    request(8'h01, 1'b1, 32'h11223344);
    wait_idle();
    check("align_writes", 64'(wr_ai.size() - w0), 64'(nexp));
    for (int i = 0; i < nexp; i++) begin
      check($sformatf("align_ai%0d", i), 64'(wr_ai[w0+i]), 64'(17'h101 + i));
      check($sformatf("align_vi%0d", i), 64'(wr_vi[w0+i]), 64'(exp_al[i]));
    end
    check("align_here", 64'(here_o), 64'(17'h101 + nexp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
